mem_resp_stage: RTL and testbench

//  Parametrised MEM pipeline stage for a split request/response data bus.

---
 rtl/mem_pkg.sv | 16 +
 rtl/load_align.sv | 53 +++++
 rtl/mem_resp_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_resp_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM response stage.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam int DEST_W_DEF = 5;

    // Width of the byte offset inside one data-bus word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed B/H/W/D lane and sign- or zero-extends it.
// Purely combinational; no latency, no backpressure.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = off_w(DATA_W)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] ONES = '1;

    logic [OFF_W-1:0]  lane;
    logic [DATA_W-1:0] keep;
    logic [DATA_W-1:0] shifted;
    logic              msb;

    always_comb begin
        lane = '0;
        keep = ONES;
        case (size)
            SIZE_B: begin
                lane = off;
                keep = ONES >> (DATA_W - 8);
            end
            SIZE_H: begin
                lane = off & ~OFF_W'(1);
                keep = ONES >> (DATA_W - 16);
            end
            SIZE_W: begin
                lane = off & ~OFF_W'(3);
                keep = ONES >> (DATA_W - 32);
            end
            default: begin
                lane = '0;
                keep = ONES;
            end
        endcase
        shifted = rdata >> {lane, 3'b000};
        // keep & ~(keep >> 1) isolates the top bit of the selected lane
        msb   = |(shifted & keep & ~(keep >> 1));
        value = shifted & keep;
        if (sign_ext && msb) begin
            value = value | ~keep;
        end
    end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM stage for a split request/response bus: holds one instruction until its data_ok,
// presents the result in the data_ok cycle, buffers it while WB stalls, drops flushed responses.
module mem_resp_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEST_W  = DEST_W_DEF,
    parameter int PAY_W   = 64,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              flush_ex_req,
    input  logic              in_valid,
    output logic              in_allow,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_need_resp,
    input  logic              in_is_load,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_gr_we,
    input  logic              in_ex,
    input  logic              in_op_csr,
    input  logic [PAY_W-1:0]  in_payload,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_allow,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_gr_we,
    output logic              out_ex,
    output logic              out_op_csr,
    output logic [PAY_W-1:0]  out_payload,
    output logic              mem_ex,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_value,
    output logic              fwd_pending,
    output logic              fwd_csr,
    output logic              discard_busy
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_OUT);

    logic              valid;
    logic              got;
    logic              need_resp;
    logic              is_load;
    logic [1:0]        size;
    logic              sgn;
    logic [DEST_W-1:0] dest;
    logic              gr_we;
    logic              ex;
    logic              op_csr;
    logic [PAY_W-1:0]  payload;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rbuf;
    logic [CNT_W-1:0]  disc_cnt;

    logic              take;
    logic              drop;
    logic              ready_go;
    logic              leave;
    logic              capture;
    logic [CNT_W:0]    inc;
    logic [CNT_W:0]    cnt_sum;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] final_val;

    // A response is ours only when no flushed response is still owed ahead of it.
    assign take     = data_ok & (disc_cnt == '0) & valid & need_resp & ~got;
    assign drop     = data_ok & (disc_cnt != '0);
    assign ready_go = ~need_resp | got | take;
    assign out_valid = valid & ready_go;
    assign in_allow  = ~valid | (ready_go & out_allow);
    assign leave     = out_valid & out_allow;
    assign capture   = in_valid & in_allow;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
            got   <= 1'b0;
        end else begin
            if (in_allow) begin
                valid <= in_valid;
            end
            if (capture || leave) begin
                got <= 1'b0;
            end else if (take) begin
                got <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            result    <= in_result;
            need_resp <= in_need_resp;
            is_load   <= in_is_load;
            size      <= in_size;
            sgn       <= in_signed;
            dest      <= in_dest;
            gr_we     <= in_gr_we;
            ex        <= in_ex;
            op_csr    <= in_op_csr;
            payload   <= in_payload;
        end
        if (take) begin
            rbuf <= rdata;
        end
    end

    // Responses still owed to flushed instructions: the held waiting one plus EX's in-flight one.
    always_comb begin
        inc = '0;
        if (flush) begin
            inc = (CNT_W+1)'(valid & need_resp & ~got & ~take) + (CNT_W+1)'(flush_ex_req);
        end
        cnt_sum = {1'b0, disc_cnt} + inc - (CNT_W+1)'(drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disc_cnt <= '0;
        end else if (cnt_sum > MAX_CNT) begin
            disc_cnt <= MAX_CNT[CNT_W-1:0];
        end else begin
            disc_cnt <= cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(data_ok && disc_cnt == '0 && !(valid && need_resp && !got)))
                else $error("mem_resp_stage: data_ok with no waiting instruction");
            assert (cnt_sum <= MAX_CNT)
                else $error("mem_resp_stage: discard counter overflow");
        end
    end

    assign raw = got ? rbuf : rdata;

    load_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .rdata    (raw),
        .off      (result[OFF_W-1:0]),
        .size     (size),
        .sign_ext (sgn),
        .value    (aligned)
    );

    assign final_val = is_load ? aligned : result;

    assign out_result  = final_val;
    assign out_dest    = dest;
    assign out_gr_we   = gr_we;
    assign out_ex      = ex;
    assign out_op_csr  = op_csr;
    assign out_payload = payload;

    assign mem_ex       = valid & ex;
    assign fwd_dest     = valid ? dest : '0;
    assign fwd_value    = final_val;
    assign fwd_pending  = valid & is_load & ~got & ~take;
    assign fwd_csr      = valid & op_csr;
    assign discard_busy = disc_cnt != '0;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: transaction-level model of the stage occupant and an in-order bus
// whose outstanding responses are tagged live or dead; DATA_W=64 instance covers the wide lanes.
module tb_mem_resp_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, flush_ex_req;
    logic        in_valid, in_allow;
    logic [31:0] in_result;
    logic        in_need_resp, in_is_load, in_signed, in_gr_we, in_ex, in_op_csr;
    logic [1:0]  in_size;
    logic [4:0]  in_dest;
    logic [63:0] in_payload;
    logic        data_ok;
    logic [31:0] rdata;
    logic        out_valid, out_allow;
    logic [31:0] out_result, fwd_value;
    logic [4:0]  out_dest, fwd_dest;
    logic        out_gr_we, out_ex, out_op_csr, mem_ex, fwd_pending, fwd_csr, discard_busy;
    logic [63:0] out_payload;

    logic        w_in_valid, w_in_allow, w_data_ok, w_signed, w_out_valid;
    logic [1:0]  w_size;
    logic [63:0] w_in_result, w_rdata, w_out_result, w_fwd_value, w_out_payload;
    logic [4:0]  w_out_dest, w_fwd_dest;
    logic        w_out_gr_we, w_out_ex, w_out_op_csr, w_mem_ex, w_fwd_pending, w_fwd_csr, w_discard_busy;

    always #5 clk = ~clk;

    mem_resp_stage #(.DATA_W(32), .DEST_W(5), .PAY_W(64), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_ex_req(flush_ex_req),
        .in_valid(in_valid), .in_allow(in_allow), .in_result(in_result),
        .in_need_resp(in_need_resp), .in_is_load(in_is_load), .in_size(in_size),
        .in_signed(in_signed), .in_dest(in_dest), .in_gr_we(in_gr_we), .in_ex(in_ex),
        .in_op_csr(in_op_csr), .in_payload(in_payload), .data_ok(data_ok), .rdata(rdata),
        .out_valid(out_valid), .out_allow(out_allow), .out_result(out_result),
        .out_dest(out_dest), .out_gr_we(out_gr_we), .out_ex(out_ex), .out_op_csr(out_op_csr),
        .out_payload(out_payload), .mem_ex(mem_ex), .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .fwd_pending(fwd_pending), .fwd_csr(fwd_csr), .discard_busy(discard_busy)
    );

    mem_resp_stage #(.DATA_W(64), .DEST_W(5), .PAY_W(64), .MAX_OUT(2)) dut64 (
        .clk(clk), .reset(reset), .flush(1'b0), .flush_ex_req(1'b0),
        .in_valid(w_in_valid), .in_allow(w_in_allow), .in_result(w_in_result),
        .in_need_resp(1'b1), .in_is_load(1'b1), .in_size(w_size),
        .in_signed(w_signed), .in_dest(5'd9), .in_gr_we(1'b1), .in_ex(1'b0),
        .in_op_csr(1'b0), .in_payload(64'h0), .data_ok(w_data_ok), .rdata(w_rdata),
        .out_valid(w_out_valid), .out_allow(1'b1), .out_result(w_out_result),
        .out_dest(w_out_dest), .out_gr_we(w_out_gr_we), .out_ex(w_out_ex), .out_op_csr(w_out_op_csr),
        .out_payload(w_out_payload), .mem_ex(w_mem_ex), .fwd_dest(w_fwd_dest), .fwd_value(w_fwd_value),
        .fwd_pending(w_fwd_pending), .fwd_csr(w_fwd_csr), .discard_busy(w_discard_busy)
    );

    typedef struct {
        bit        need_resp, is_load, sgn, gr_we, ex, op_csr, got;
        bit [1:0]  size;
        bit [4:0]  dest;
        bit [31:0] result, rd;
        bit [63:0] payload;
    } instr_t;

    int     total = 0;
    int     bad = 0;
    bit     occ;
    instr_t cur;
    bit     q[$];   // outstanding bus responses in order: 1 = owed to the occupant, 0 = flushed
    bit     e_take, e_done;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Lane selection by plain arithmetic: lane index = offset / lane bytes.
    function automatic logic [63:0] ref_align(input logic [63:0] d, input int off, input int sz,
                                              input bit sg, input int w);
        int nb;
        int idx;
        logic [63:0] v;
        case (sz)
            0: nb = 1;
            1: nb = 2;
            2: nb = 4;
            default: nb = w / 8;
        endcase
        if (nb > w / 8) nb = w / 8;
        idx = off / nb;
        v = d >> (idx * nb * 8);
        if (nb < 8) v = v & ((64'd1 << (nb * 8)) - 64'd1);
        if (sg && nb < w / 8 && v[nb*8-1]) v = v - (64'd1 << (nb * 8));
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    function automatic int count_dead();
        int n = 0;
        foreach (q[i]) if (!q[i]) n++;
        return n;
    endfunction

    task automatic look();
        logic [31:0] exp_res;
        @(negedge clk);
        e_take = data_ok && q.size() > 0 && q[0];
        e_done = occ && (!cur.need_resp || cur.got || e_take);
        chk("out_valid", out_valid, e_done);
        chk("in_allow", in_allow, !occ || (e_done && out_allow));
        chk("discard_busy", discard_busy, count_dead() != 0);
        chk("mem_ex", mem_ex, occ && cur.ex);
        chk("fwd_dest", fwd_dest, occ ? cur.dest : 5'd0);
        chk("fwd_csr", fwd_csr, occ && cur.op_csr);
        chk("fwd_pending", fwd_pending, occ && cur.is_load && !cur.got && !e_take);
        if (e_done) begin
            exp_res = cur.is_load ?
                32'(ref_align(64'(cur.got ? cur.rd : rdata), int'(cur.result[1:0]), int'(cur.size), cur.sgn, 32))
                : cur.result;
            chk("out_result", out_result, exp_res);
            chk("fwd_value", fwd_value, exp_res);
            chk("out_dest", out_dest, cur.dest);
            chk("out_gr_we", out_gr_we, cur.gr_we);
            chk("out_ex", out_ex, cur.ex);
            chk("out_op_csr", out_op_csr, cur.op_csr);
            chk("out_payload", out_payload, cur.payload);
        end
    endtask

    task automatic adv();
        if (data_ok && q.size() > 0) begin
            if (q[0]) begin
                cur.got = 1'b1;
                cur.rd  = rdata;
            end
            void'(q.pop_front());
        end
        if (flush) begin
            foreach (q[i]) q[i] = 1'b0;
            occ = 1'b0;
            if (flush_ex_req) q.push_back(1'b0);
        end else if (!occ || (e_done && out_allow)) begin
            occ = in_valid;
            if (in_valid) begin
                cur.need_resp = in_need_resp; cur.is_load = in_is_load; cur.sgn = in_signed;
                cur.gr_we = in_gr_we; cur.ex = in_ex; cur.op_csr = in_op_csr; cur.size = in_size;
                cur.dest = in_dest; cur.result = in_result; cur.payload = in_payload;
                cur.got = 1'b0;
                if (in_need_resp) q.push_back(1'b1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit nr, input bit ld, input logic [1:0] sz, input bit sg,
                       input logic [31:0] res, input logic [4:0] d, input bit exb);
        in_valid = 1'b1; in_need_resp = nr; in_is_load = ld; in_size = sz; in_signed = sg;
        in_result = res; in_dest = d; in_gr_we = (d != 0); in_ex = exb; in_op_csr = 1'b0;
        in_payload = {$urandom, $urandom};
    endtask

    task automatic rnd_inputs(input int p_resp, input int p_allow, input int p_in);
        int proj;
        bit live, exr;
        int kind;
        data_ok   = q.size() > 0 && ($urandom_range(99) < p_resp);
        rdata     = $urandom;
        out_allow = $urandom_range(99) < p_allow;
        live = 1'b0;
        foreach (q[i]) if (q[i]) live = 1'b1;
        proj = count_dead() - ((data_ok && !q[0]) ? 1 : 0) + ((live && !(data_ok && q[0])) ? 1 : 0);
        flush = 1'b0;
        flush_ex_req = 1'b0;
        if ($urandom_range(99) < 5) begin
            exr = 1'($urandom_range(1));
            if (proj + int'(exr) <= 2) begin
                flush = 1'b1;
                flush_ex_req = exr;
            end else if (proj <= 2) begin
                flush = 1'b1;
            end
        end
        kind = $urandom_range(2);
        put(kind != 0, kind == 1, 2'($urandom_range(2)), 1'($urandom_range(1)), $urandom,
            5'($urandom), $urandom_range(9) == 0);
        in_op_csr = $urandom_range(7) == 0;
        in_valid  = !flush && ($urandom_range(99) < p_in);
    endtask

    initial begin
        reset = 1'b1; flush = 0; flush_ex_req = 0; in_valid = 0; in_result = 0;
        in_need_resp = 0; in_is_load = 0; in_size = 0; in_signed = 0; in_dest = 0;
        in_gr_we = 0; in_ex = 0; in_op_csr = 0; in_payload = 0; data_ok = 0; rdata = 0;
        out_allow = 1;
        w_in_valid = 0; w_in_result = 0; w_size = 0; w_signed = 0; w_data_ok = 0; w_rdata = 0;
        occ = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        look();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_allow", in_allow, 1'b1);
        chk("reset discard_busy", discard_busy, 1'b0);
        chk("reset w_out_valid", w_out_valid, 1'b0);
        adv();

        chk("model ldb", ref_align(64'h80FF1234, 3, 0, 1, 32), 64'hFFFFFF80);
        chk("model ldhu", ref_align(64'hBEEF0000, 2, 1, 0, 32), 64'h0000BEEF);
        chk("model ldd", ref_align(64'h0123456789ABCDEF, 0, 3, 0, 64), 64'h0123456789ABCDEF);
        chk("model ldw64", ref_align(64'h8000000000000000, 4, 2, 1, 64), 64'hFFFFFFFF80000000);

        // ld.b signed, response two cycles late
        put(1, 1, 2'b00, 1, 32'h00001003, 5'd5, 0);
        look(); adv(); in_valid = 0;
        look(); chk("t1 pending a", fwd_pending, 1'b1); adv();
        look(); chk("t1 pending b", fwd_pending, 1'b1); chk("t1 no valid", out_valid, 1'b0); adv();
        data_ok = 1; rdata = 32'h80FF1234;
        look(); chk("t1 valid", out_valid, 1'b1); chk("t1 result", out_result, 32'hFFFFFF80);
        chk("t1 pending clr", fwd_pending, 1'b0); adv();
        data_ok = 0;

        // ld.hu off 2 with WB stalled for three cycles
        put(1, 1, 2'b01, 0, 32'h00002002, 5'd6, 0);
        look(); adv(); in_valid = 0;
        out_allow = 0; data_ok = 1; rdata = 32'hBEEF0000;
        look(); chk("t2 result", out_result, 32'h0000BEEF); chk("t2 in_allow", in_allow, 1'b0); adv();
        data_ok = 0;
        for (int i = 0; i < 2; i++) begin
            rdata = $urandom;
            look(); chk("t2 held", out_result, 32'h0000BEEF); chk("t2 stall", in_allow, 1'b0); adv();
        end
        out_allow = 1;
        look(); chk("t2 release", in_allow, 1'b1); chk("t2 final", out_result, 32'h0000BEEF); adv();

        // flush of a waiting load plus EX's in-flight request: two responses dropped
        put(1, 1, 2'b10, 0, 32'h00003000, 5'd7, 0);
        look(); adv(); in_valid = 0;
        flush = 1; flush_ex_req = 1;
        look(); adv();
        flush = 0; flush_ex_req = 0;
        put(1, 1, 2'b10, 0, 32'h00003004, 5'd8, 0);
        look(); chk("t3 busy", discard_busy, 1'b1); adv(); in_valid = 0;
        data_ok = 1; rdata = 32'hDEAD0001;
        look(); chk("t3 drop a", out_valid, 1'b0); adv();
        rdata = 32'hDEAD0002;
        look(); chk("t3 drop b", out_valid, 1'b0); chk("t3 busy b", discard_busy, 1'b1); adv();
        rdata = 32'h00000011;
        look(); chk("t3 idle", discard_busy, 1'b0); chk("t3 valid", out_valid, 1'b1);
        chk("t3 result", out_result, 32'h00000011); adv();
        data_ok = 0;

        // back-to-back ALU ops and stores, immediate responses
        for (int i = 0; i < 8; i++) begin
            put(i % 2 == 1, 0, 2'b10, 0, $urandom, 5'(i + 1), 0);
            data_ok = q.size() > 0; rdata = $urandom;
            look();
            chk("t4 in_allow", in_allow, 1'b1);
            if (i > 0) begin
                chk("t4 out_valid", out_valid, 1'b1);
                chk("t4 pending", fwd_pending, 1'b0);
            end
            adv();
        end
        in_valid = 0; data_ok = q.size() > 0;
        look(); adv();
        data_ok = 0;

        // ertn-style instruction: mem_ex until the flush
        put(0, 0, 2'b10, 0, 32'h00005000, 5'd0, 1);
        look(); adv(); in_valid = 0; out_allow = 0;
        look(); chk("t5 mem_ex", mem_ex, 1'b1); adv();
        flush = 1;
        look(); adv();
        flush = 0; out_allow = 1;
        look(); chk("t5 mem_ex clr", mem_ex, 1'b0); chk("t5 empty", out_valid, 1'b0); adv();

        // 64-bit lanes; the 32-bit stage stays idle meanwhile
        w_in_valid = 1; w_in_result = 64'h0; w_size = 2'b11; w_signed = 0;
        @(negedge clk); chk("t6 w_in_allow", w_in_allow, 1'b1);
        @(posedge clk); #1;
        w_in_valid = 0; w_data_ok = 1; w_rdata = 64'h0123456789ABCDEF;
        @(negedge clk);
        chk("t6 ldd valid", w_out_valid, 1'b1);
        chk("t6 ldd", w_out_result, 64'h0123456789ABCDEF);
        @(posedge clk); #1;
        w_data_ok = 0; w_in_valid = 1; w_in_result = 64'h4; w_size = 2'b10; w_signed = 1;
        @(posedge clk); #1;
        w_in_valid = 0; w_data_ok = 1; w_rdata = 64'h8000000000000000;
        @(negedge clk);
        chk("t6 ldw valid", w_out_valid, 1'b1);
        chk("t6 ldw", w_out_result, 64'hFFFFFFFF80000000);
        chk("t6 ldw model", w_out_result, ref_align(w_rdata, 4, 2, 1, 64));
        @(posedge clk); #1;
        w_data_ok = 0;

        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 700; c++) begin
                case (ph)
                    0: rnd_inputs(50, 70, 60);
                    1: rnd_inputs(90, 100, 90);
                    2: rnd_inputs(20, 40, 50);
                    default: rnd_inputs(70, 85, 70);
                endcase
                look();
                adv();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
